maxpool2d_stream: RTL and testbench



---
 rtl/maxpool2d_stream_if.sv | 25 ++
 rtl/maxpool2d_stream.sv | 175 +++++++++++++++++
 tb/tb_maxpool2d_stream.sv | 261 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/maxpool2d_stream_if.sv
// Valid/ready element stream between the conv, pool and next-layer stages.
// master drives data/valid/last and samples ready; slave is the reverse.
interface maxpool2d_stream_if #(
    parameter int DATA_WIDTH = 32
);
    logic [DATA_WIDTH-1:0] data;
    logic                  valid;
    logic                  ready;
    logic                  last;

    modport master (
        output data,
        output valid,
        output last,
        input  ready
    );

    // The pool stage infers frame position from its own counters and has
    // no use for an upstream last flag.
    modport slave (
        input  data,
        input  valid,
        output ready
    );
endinterface

// File: rtl/maxpool2d_stream.sv
// Streaming 2x2 stride-2 signed max-pool with optional ReLU, one line of
// partial maxima. Ports: clk, rst (sync, active high), in_s (slave stream),
// out_s (master stream with last), done (pulse after final output accepted).
module maxpool2d_stream #(
    parameter int DATA_WIDTH = 32,
    parameter int PLANES     = 1,
    parameter int IN_HEIGHT  = 2,
    parameter int IN_WIDTH   = 2,
    parameter int RELU       = 0
) (
    input  logic                      clk,
    input  logic                      rst,
    maxpool2d_stream_if.slave         in_s,
    maxpool2d_stream_if.master        out_s,
    output logic                      done
);
    localparam int OUT_HEIGHT = IN_HEIGHT / 2;
    localparam int OUT_WIDTH  = IN_WIDTH / 2;

    localparam int CW = $clog2(IN_WIDTH);
    localparam int RW = $clog2(IN_HEIGHT);
    localparam int PW = (PLANES > 1) ? $clog2(PLANES) : 1;
    localparam int LW = (OUT_WIDTH > 1) ? $clog2(OUT_WIDTH) : 1;

    localparam logic [CW-1:0] COL_MAX      = CW'(IN_WIDTH - 1);
    localparam logic [CW-1:0] COL_POOL_MAX = CW'(2 * OUT_WIDTH - 1);
    localparam logic [RW-1:0] ROW_MAX      = RW'(IN_HEIGHT - 1);
    localparam logic [RW-1:0] ROW_POOL_MAX = RW'(2 * OUT_HEIGHT - 1);
    localparam logic [PW-1:0] PLANE_MAX    = PW'(PLANES - 1);

    typedef logic signed [DATA_WIDTH-1:0] elem_t;

    logic [CW-1:0] col_q, col_d;
    logic [RW-1:0] row_q, row_d;
    logic [PW-1:0] plane_q, plane_d;
    elem_t         pair_q, pair_d;
    elem_t         lb_q [OUT_WIDTH];
    elem_t         lb_d [OUT_WIDTH];
    elem_t         out_data_q, out_data_d;
    logic          out_valid_q, out_valid_d;
    logic          out_last_q, out_last_d;
    logic          done_q, done_d;

    logic          in_ready;
    logic          in_fire;
    logic          out_fire;
    logic          col_end;
    logic          row_end;
    logic          plane_end;
    logic          col_pool;
    logic          row_pool;
    logic          complete;
    logic          is_last;
    logic [LW-1:0] lb_idx;
    elem_t         in_elem;
    elem_t         hmax;
    elem_t         vmax;
    elem_t         result;

    assign in_elem = elem_t'(in_s.data);

    always_comb begin
        // Single output register: room exists if empty or draining now.
        in_ready  = !out_valid_q || out_s.ready;
        in_fire   = in_s.valid && in_ready;
        out_fire  = out_valid_q && out_s.ready;

        col_end   = (col_q == COL_MAX);
        row_end   = (row_q == ROW_MAX);
        plane_end = (plane_q == PLANE_MAX);

        // Trailing odd column/row fall outside every window.
        col_pool  = (col_q <= COL_POOL_MAX);
        row_pool  = (row_q <= ROW_POOL_MAX);

        lb_idx    = LW'(col_q >> 1);
        hmax      = (in_elem > pair_q) ? in_elem : pair_q;
        vmax      = (lb_q[lb_idx] > hmax) ? lb_q[lb_idx] : hmax;
        result    = ((RELU != 0) && (vmax < 0)) ? '0 : vmax;

        is_last   = plane_end
                 && (row_q == ROW_POOL_MAX)
                 && (col_q == COL_POOL_MAX);

        col_d       = col_q;
        row_d       = row_q;
        plane_d     = plane_q;
        pair_d      = pair_q;
        lb_d        = lb_q;
        complete    = 1'b0;

        if (in_fire) begin
            if (col_end) begin
                col_d = '0;
                if (row_end) begin
                    row_d   = '0;
                    plane_d = plane_end ? '0 : plane_q + PW'(1);
                end else begin
                    row_d = row_q + RW'(1);
                end
            end else begin
                col_d = col_q + CW'(1);
            end

            if (col_pool && !col_q[0]) begin
                pair_d = in_elem;
            end

            if (col_pool && col_q[0] && row_pool) begin
                if (!row_q[0]) begin
                    lb_d[lb_idx] = hmax;
                end else begin
                    complete = 1'b1;
                end
            end
        end

        out_data_d  = out_data_q;
        out_valid_d = out_valid_q;
        out_last_d  = out_last_q;

        // A new result wins over a drain on the same edge, so out_valid
        // stays high across back-to-back results.
        if (complete) begin
            out_data_d  = result;
            out_valid_d = 1'b1;
            out_last_d  = is_last;
        end else if (out_fire) begin
            out_valid_d = 1'b0;
            out_last_d  = 1'b0;
        end

        done_d = out_fire && out_last_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            col_q       <= '0;
            row_q       <= '0;
            plane_q     <= '0;
            pair_q      <= '0;
            out_data_q  <= '0;
            out_valid_q <= 1'b0;
            out_last_q  <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            col_q       <= col_d;
            row_q       <= row_d;
            plane_q     <= plane_d;
            pair_q      <= pair_d;
            out_data_q  <= out_data_d;
            out_valid_q <= out_valid_d;
            out_last_q  <= out_last_d;
            done_q      <= done_d;
        end
    end

    // Every entry is rewritten on an even row before it is read, so the
    // line buffer carries no reset.
    always_ff @(posedge clk) begin
        lb_q <= lb_d;
    end

    assign in_s.ready  = in_ready;
    assign out_s.data  = out_data_q;
    assign out_s.valid = out_valid_q;
    assign out_s.last  = out_last_q;
    assign done        = done_q;

    a_stall_hold: assert property (
        @(posedge clk) disable iff (rst)
        (out_valid_q && !out_s.ready) |=>
        (out_valid_q && $stable(out_data_q) && $stable(out_last_q))
    );
endmodule

// File: tb/tb_maxpool2d_stream.sv
// Directed bench for maxpool2d_stream: four parameterisations behind a
// shared driver, outputs checked against hand-computed pooled values.
module tb_maxpool2d_stream;
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic [31:0] drv_data;
    logic        drv_valid;
    logic        drv_oready;
    int          sel;

    maxpool2d_stream_if #(.DATA_WIDTH(32)) ia ();
    maxpool2d_stream_if #(.DATA_WIDTH(32)) oa ();
    maxpool2d_stream_if #(.DATA_WIDTH(32)) ib ();
    maxpool2d_stream_if #(.DATA_WIDTH(32)) ob ();
    maxpool2d_stream_if #(.DATA_WIDTH(32)) ic ();
    maxpool2d_stream_if #(.DATA_WIDTH(32)) oc ();
    maxpool2d_stream_if #(.DATA_WIDTH(32)) id ();
    maxpool2d_stream_if #(.DATA_WIDTH(32)) od ();
    logic done_a, done_b, done_c, done_d;

    assign ia.data  = drv_data;
    assign ib.data  = drv_data;
    assign ic.data  = drv_data;
    assign id.data  = drv_data;
    assign ia.valid = drv_valid && (sel == 0);
    assign ib.valid = drv_valid && (sel == 1);
    assign ic.valid = drv_valid && (sel == 2);
    assign id.valid = drv_valid && (sel == 3);
    assign ia.last  = 1'b0;
    assign ib.last  = 1'b0;
    assign ic.last  = 1'b0;
    assign id.last  = 1'b0;
    assign oa.ready = drv_oready;
    assign ob.ready = drv_oready;
    assign oc.ready = drv_oready;
    assign od.ready = drv_oready;

    maxpool2d_stream #(
        .DATA_WIDTH(32), .PLANES(1), .IN_HEIGHT(4),
        .IN_WIDTH(4), .RELU(0)
    ) u_a (
        .clk(clk), .rst(rst), .in_s(ia), .out_s(oa), .done(done_a)
    );

    maxpool2d_stream #(
        .DATA_WIDTH(32), .PLANES(1), .IN_HEIGHT(4),
        .IN_WIDTH(4), .RELU(1)
    ) u_b (
        .clk(clk), .rst(rst), .in_s(ib), .out_s(ob), .done(done_b)
    );

    maxpool2d_stream #(
        .DATA_WIDTH(32), .PLANES(1), .IN_HEIGHT(5),
        .IN_WIDTH(5), .RELU(0)
    ) u_c (
        .clk(clk), .rst(rst), .in_s(ic), .out_s(oc), .done(done_c)
    );

    maxpool2d_stream #(
        .DATA_WIDTH(32), .PLANES(2), .IN_HEIGHT(4),
        .IN_WIDTH(4), .RELU(0)
    ) u_d (
        .clk(clk), .rst(rst), .in_s(id), .out_s(od), .done(done_d)
    );

    logic [31:0] mon_data;
    logic        mon_valid;
    logic        mon_last;
    logic        mon_done;
    logic        mon_iready;

    always_comb begin
        mon_data   = '0;
        mon_valid  = 1'b0;
        mon_last   = 1'b0;
        mon_done   = 1'b0;
        mon_iready = 1'b0;
        case (sel)
            0: begin
                mon_data = oa.data; mon_valid = oa.valid;
                mon_last = oa.last; mon_done = done_a;
                mon_iready = ia.ready;
            end
            1: begin
                mon_data = ob.data; mon_valid = ob.valid;
                mon_last = ob.last; mon_done = done_b;
                mon_iready = ib.ready;
            end
            2: begin
                mon_data = oc.data; mon_valid = oc.valid;
                mon_last = oc.last; mon_done = done_c;
                mon_iready = ic.ready;
            end
            default: begin
                mon_data = od.data; mon_valid = od.valid;
                mon_last = od.last; mon_done = done_d;
                mon_iready = id.ready;
            end
        endcase
    end

    int n_cmp = 0;
    int n_bad = 0;
    int vin[$];
    int vexp[$];

    task automatic check(input string tag,
                         input logic signed [31:0] obs,
                         input logic signed [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d want %0d", tag, obs, exp);
        end
    endtask

    // Called just after a falling edge; returns at the same phase.
    task automatic run(input int s, input bit stall_en, input string nm);
        int          idx = 0;
        int          nout = 0;
        int          stall = 0;
        int          cyc = 0;
        int          ndone = 0;
        bit          pend = 1'b0;
        bit          prev_v = 1'b0;
        bit          acc_in;
        bit          acc_out;
        logic [31:0] held = '0;
        sel = s;
        #1;
        while ((idx < vin.size() || nout < vexp.size() || pend)
               && cyc < 2000) begin
            drv_valid = (idx < vin.size());
            drv_data  = drv_valid ? vin[idx] : '0;
            if (stall_en && mon_valid && !prev_v) begin
                stall = 5;
                held  = mon_data;
            end
            drv_oready = (stall == 0);
            #1;
            check({nm, "/done"}, mon_done, pend);
            if (mon_done) ndone++;
            check({nm, "/in_ready"}, mon_iready,
                  !mon_valid || drv_oready);
            if (stall > 0 && stall < 5) begin
                check({nm, "/stall_data"}, mon_data, held);
                check({nm, "/stall_valid"}, mon_valid, 1);
            end
            acc_in  = drv_valid && mon_iready;
            acc_out = mon_valid && drv_oready;
            pend    = 1'b0;
            if (acc_out) begin
                if (nout < vexp.size()) begin
                    check({nm, "/data"}, mon_data, vexp[nout]);
                    check({nm, "/last"}, mon_last,
                          nout == vexp.size() - 1);
                end else begin
                    check({nm, "/extra_out"}, nout + 1, vexp.size());
                end
                pend = mon_last;
                nout++;
            end
            prev_v = mon_valid;
            if (stall > 0) stall--;
            @(posedge clk);
            if (acc_in) idx++;
            @(negedge clk);
            #1;
            cyc++;
        end
        check({nm, "/n_in"}, idx, vin.size());
        check({nm, "/n_out"}, nout, vexp.size());
        check({nm, "/n_done"}, ndone, 1);
        drv_valid  = 1'b0;
        drv_oready = 1'b1;
        repeat (3) begin
            @(negedge clk);
            #1;
            check({nm, "/idle_valid"}, mon_valid, 0);
            check({nm, "/idle_done"}, mon_done, 0);
        end
    endtask

    task automatic ramp(input int base, input int n);
        for (int i = 0; i < n; i++) vin.push_back(base + i);
    endtask

    initial begin
        rst        = 1'b1;
        drv_data   = '0;
        drv_valid  = 1'b0;
        drv_oready = 1'b1;
        sel        = 0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        #1;
        check("rst/valid", mon_valid, 0);
        check("rst/data", mon_data, 0);
        check("rst/last", mon_last, 0);
        check("rst/done", mon_done, 0);
        rst = 1'b0;
        @(negedge clk);
        check("rst/in_ready", mon_iready, 1);

        vin = {}; ramp(1, 16);
        vexp = '{6, 8, 14, 16};
        run(0, 1'b0, "a_ramp");

        vin = {}; ramp(-16, 16);
        vexp = '{-11, -9, -3, -1};
        run(0, 1'b0, "a_neg");
        vexp = '{0, 0, 0, 0};
        run(1, 1'b0, "b_neg_relu");

        vin = '{3, -7, -2, -9, -1, 2, -8, -1,
                -6, 5, 1, -3, 4, -5, 8, -5};
        vexp = '{3, -1, 5, 8};
        run(0, 1'b0, "a_mixed");
        vexp = '{3, 0, 5, 8};
        run(1, 1'b0, "b_mixed_relu");

        vin = {}; ramp(0, 25);
        vexp = '{6, 8, 16, 18};
        run(2, 1'b0, "c_5x5");

        vin = {}; ramp(1, 16); ramp(101, 16);
        vexp = '{6, 8, 14, 16, 106, 108, 114, 116};
        run(3, 1'b0, "d_planes");

        vin = {}; ramp(1, 16);
        vexp = '{6, 8, 14, 16};
        run(0, 1'b1, "a_stall");

        sel = 0;
        drv_oready = 1'b1;
        for (int k = 0; k < 7; k++) begin
            drv_valid = 1'b1;
            drv_data  = k + 1;
            @(posedge clk);
            @(negedge clk);
        end
        drv_valid = 1'b0;
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("mid_rst/valid", mon_valid, 0);
        check("mid_rst/data", mon_data, 0);
        check("mid_rst/last", mon_last, 0);
        check("mid_rst/in_ready", mon_iready, 1);
        @(negedge clk);
        run(0, 1'b0, "a_after_rst");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end
endmodule
